// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel position, sync, blanking, strobes, frame count.
// Ports: clk_pix, rst (sync, active-high), en; sx/sy, hsync/vsync, de,
//   hblank/vblank, line_start/frame_start, frame_cnt -- all registered.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0,
   parameter int CORDW    = 10,
   parameter int FCW      = 8
) (
   input  logic             clk_pix,
   input  logic             rst,
   input  logic             en,
   output logic [CORDW-1:0] sx,
   output logic [CORDW-1:0] sy,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic             hblank,
   output logic             vblank,
   output logic             line_start,
   output logic             frame_start,
   output logic [FCW-1:0]   frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_chk_min
      $error("vga_timing_gen: timing parameters must be >= 1");
   end
   if (H_TOTAL > (1 << CORDW) || V_TOTAL > (1 << CORDW)) begin : g_chk_width
      $error("vga_timing_gen: CORDW too small for H_TOTAL/V_TOTAL");
   end

   localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
   localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
   localparam logic [CORDW-1:0] HA_C   = CORDW'(H_ACTIVE);
   localparam logic [CORDW-1:0] VA_C   = CORDW'(V_ACTIVE);
   localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_ACTIVE + H_FP);
   localparam logic [CORDW-1:0] HS_END = CORDW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_ACTIVE + V_FP);
   localparam logic [CORDW-1:0] VS_END = CORDW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic             HP     = (H_POL != 0);
   localparam logic             VP     = (V_POL != 0);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [CORDW-1:0] sx_d, sy_d;
   logic [FCW-1:0]   fc_d;
   logic             hs_d, vs_d, hb_d, vb_d;

   // Next position is decoded here so every registered flag lines up
   // with the coordinates loaded on the same edge.
   always_comb begin
      state_d = state_q;
      sx_d    = sx;
      sy_d    = sy;
      fc_d    = frame_cnt;
      unique case (state_q)
         IDLE: begin
            state_d = RUN;
            sx_d    = '0;
            sy_d    = '0;
         end
         RUN: begin
            if (sx == H_LAST) begin
               sx_d = '0;
               if (sy == V_LAST) begin
                  sy_d = '0;
                  fc_d = frame_cnt + FCW'(1);
               end else begin
                  sy_d = sy + CORDW'(1);
               end
            end else begin
               sx_d = sx + CORDW'(1);
            end
         end
      endcase
      hb_d = (sx_d >= HA_C);
      vb_d = (sy_d >= VA_C);
      hs_d = (sx_d >= HS_BEG) && (sx_d <= HS_END);
      vs_d = (sy_d >= VS_BEG) && (sy_d <= VS_END);
   end

   always_ff @(posedge clk_pix) begin
      if (rst) begin
         state_q     <= IDLE;
         sx          <= '0;
         sy          <= '0;
         hsync       <= ~HP;
         vsync       <= ~VP;
         de          <= 1'b0;
         hblank      <= 1'b0;
         vblank      <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
      end else if (en) begin
         state_q     <= state_d;
         sx          <= sx_d;
         sy          <= sy_d;
         hsync       <= hs_d ? HP : ~HP;
         vsync       <= vs_d ? VP : ~VP;
         de          <= ~hb_d & ~vb_d;
         hblank      <= hb_d;
         vblank      <= vb_d;
         line_start  <= (sx_d == '0);
         frame_start <= (sx_d == '0) && (sy_d == '0);
         frame_cnt   <= fc_d;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three modes checked against an arithmetic
// model of enabled-cycle count versus raster position.
module tb_vga_timing_gen;

   localparam int HA [3] = '{640, 4, 5};
   localparam int HF [3] = '{16, 1, 2};
   localparam int HS [3] = '{96, 2, 3};
   localparam int HB [3] = '{48, 1, 2};
   localparam int VA [3] = '{480, 3, 4};
   localparam int VF [3] = '{10, 1, 2};
   localparam int VS [3] = '{2, 1, 2};
   localparam int VB [3] = '{33, 1, 3};
   localparam int HP [3] = '{0, 1, 0};
   localparam int VP [3] = '{0, 1, 0};
   localparam int FW [3] = '{8, 2, 8};

   logic       clk = 1'b0;
   logic [2:0] rst_v = 3'b111;
   logic [2:0] en_v = 3'b000;

   always #5 clk = ~clk;

   logic [9:0] sx_a, sy_a;
   logic [2:0] sx_b, sy_b;
   logic [3:0] sx_c, sy_c;
   logic [7:0] fc_a, fc_c;
   logic [1:0] fc_b;
   logic hs_a, vs_a, de_a, hb_a, vb_a, ls_a, fs_a;
   logic hs_b, vs_b, de_b, hb_b, vb_b, ls_b, fs_b;
   logic hs_c, vs_c, de_c, hb_c, vb_c, ls_c, fs_c;

   vga_timing_gen u_a (
      .clk_pix(clk), .rst(rst_v[0]), .en(en_v[0]),
      .sx(sx_a), .sy(sy_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
      .hblank(hb_a), .vblank(vb_a), .line_start(ls_a),
      .frame_start(fs_a), .frame_cnt(fc_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(1), .V_POL(1), .CORDW(3), .FCW(2)
   ) u_b (
      .clk_pix(clk), .rst(rst_v[1]), .en(en_v[1]),
      .sx(sx_b), .sy(sy_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
      .hblank(hb_b), .vblank(vb_b), .line_start(ls_b),
      .frame_start(fs_b), .frame_cnt(fc_b)
   );

   vga_timing_gen #(
      .H_ACTIVE(5), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .H_POL(0), .V_POL(0), .CORDW(4), .FCW(8)
   ) u_c (
      .clk_pix(clk), .rst(rst_v[2]), .en(en_v[2]),
      .sx(sx_c), .sy(sy_c), .hsync(hs_c), .vsync(vs_c), .de(de_c),
      .hblank(hb_c), .vblank(vb_c), .line_start(ls_c),
      .frame_start(fs_c), .frame_cnt(fc_c)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   bit     run [3];
   longint k [3];

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [63:0] pack(
      input logic [9:0] x, input logic [9:0] y,
      input logic hs, input logic vs, input logic d,
      input logic hb, input logic vb, input logic ls,
      input logic fs, input logic [7:0] fc);
      return {29'b0, x, y, hs, vs, d, hb, vb, ls, fs, fc};
   endfunction

   // Expected outputs from the enabled-cycle count k since entering RUN.
   function automatic logic [63:0] model_out(input int i);
      longint ht, vt, x, y, f;
      logic hp, vp, hs, vs;
      hp = (HP[i] != 0);
      vp = (VP[i] != 0);
      if (!run[i])
         return pack(10'd0, 10'd0, !hp, !vp, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b0, 8'd0);
      ht = HA[i] + HF[i] + HS[i] + HB[i];
      vt = VA[i] + VF[i] + VS[i] + VB[i];
      x = k[i] % ht;
      y = (k[i] / ht) % vt;
      f = (k[i] / (ht * vt)) % (longint'(1) << FW[i]);
      hs = (x >= HA[i] + HF[i] && x < HA[i] + HF[i] + HS[i]) ? hp : !hp;
      vs = (y >= VA[i] + VF[i] && y < VA[i] + VF[i] + VS[i]) ? vp : !vp;
      return pack(10'(x), 10'(y), hs, vs, (x < HA[i]) && (y < VA[i]),
                  x >= HA[i], y >= VA[i], x == 0, x == 0 && y == 0, 8'(f));
   endfunction

   task automatic tick();
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
         if (rst_v[i]) begin
            run[i] = 1'b0;
            k[i] = 0;
         end else if (en_v[i]) begin
            if (!run[i]) run[i] = 1'b1;
            else k[i]++;
         end
      end
      #1;
      check("A", pack(sx_a, sy_a, hs_a, vs_a, de_a, hb_a, vb_a,
                      ls_a, fs_a, fc_a), model_out(0));
      check("B", pack({7'b0, sx_b}, {7'b0, sy_b}, hs_b, vs_b, de_b, hb_b,
                      vb_b, ls_b, fs_b, {6'b0, fc_b}), model_out(1));
      check("C", pack({6'b0, sx_c}, {6'b0, sy_c}, hs_c, vs_c, de_c, hb_c,
                      vb_c, ls_c, fs_c, fc_c), model_out(2));
   endtask

   initial begin
      int de_cnt, ls_cnt, fs_cnt, hs_cnt, guard;
      for (int i = 0; i < 3; i++) begin
         run[i] = 1'b0;
         k[i] = 0;
      end
      #1;
      // reset held three cycles, with en high to show rst wins
      rst_v = 3'b111;
      en_v = 3'b111;
      repeat (3) tick();

      rst_v = 3'b000;
      de_cnt = 0; ls_cnt = 0; fs_cnt = 0; hs_cnt = 0;
      for (int n = 1; n <= 1700; n++) begin
         tick();
         if (n == 1) check("A_first_fs", {63'b0, fs_a}, 64'd1);
         if (n <= 48) begin
            de_cnt += int'(de_b);
            ls_cnt += int'(ls_b);
            fs_cnt += int'(fs_b);
         end
         if (n <= 800) hs_cnt += int'(!hs_a);
      end
      check("B_de_per_frame", 64'(de_cnt), 64'd12);
      check("B_ls_per_frame", 64'(ls_cnt), 64'd6);
      check("B_fs_per_frame", 64'(fs_cnt), 64'd1);
      check("A_hsync_width", 64'(hs_cnt), 64'd96);

      // en pattern 1,0,0,1 on the small modes, A frozen
      en_v[0] = 1'b0;
      for (int n = 0; n < 240; n++) begin
         en_v[1] = (n % 4 == 0) || (n % 4 == 3);
         en_v[2] = en_v[1];
         tick();
      end

      // reset B mid-frame at (5,2)
      en_v = 3'b111;
      guard = 0;
      while (!(run[1] && k[1] % 8 == 5 && (k[1] / 8) % 6 == 2)
             && guard < 200) begin
         tick();
         guard++;
      end
      check("B_reach_5_2", 64'(guard < 200), 64'd1);
      rst_v[1] = 1'b1;
      tick();
      check("B_rst_fc", {62'b0, fc_b}, 64'd0);
      rst_v[1] = 1'b0;
      tick();
      check("B_rst_fs", {63'b0, fs_b}, 64'd1);

      // randomized en and occasional rst
      for (int n = 0; n < 4000; n++) begin
         for (int i = 0; i < 3; i++) begin
            en_v[i] = ($urandom_range(3) != 0);
            rst_v[i] = ($urandom_range(299) == 0);
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
